// File: rtl/debug_pkg.sv
// Shared encodings for the debug trace block: modes, capture states and
// the bit layout of the 8-bit debug config word.
package debug_pkg;

    localparam logic [1:0] MODE_LIVE    = 2'd0;
    localparam logic [1:0] MODE_SCAN    = 2'd1;
    localparam logic [1:0] MODE_CAPTURE = 2'd2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_READOUT = 2'd3;

    localparam int CHAN_LSB = 0;
    localparam int CHAN_MSB = 3;
    localparam int MODE_LSB = 4;
    localparam int MODE_MSB = 5;
    localparam int SEXT_BIT = 6;

endpackage

// File: rtl/debug_trace_module_if.sv
// Bundle of config, observed core signals, pop handshake and debug outputs.
interface debug_trace_module_if #(
    parameter int NBITS = 4,
    parameter int N_POT = 10,
    parameter int N_SPK = 8,
    parameter int OUT_W = 8
);
    logic                     en;
    logic [7:0]               debug_config_in;
    logic [N_POT*NBITS-1:0]   membrane_potentials;
    logic [N_SPK-1:0]         output_spikes_layer1;
    logic                     rd_en;
    logic [OUT_W-1:0]         debug_select;
    logic                     debug_valid;
    logic [3:0]               debug_chan;
    logic [1:0]               debug_state;

    modport master (
        output en, debug_config_in, membrane_potentials, output_spikes_layer1, rd_en,
        input  debug_select, debug_valid, debug_chan, debug_state
    );

    modport slave (
        input  en, debug_config_in, membrane_potentials, output_spikes_layer1, rd_en,
        output debug_select, debug_valid, debug_chan, debug_state
    );
endinterface

// File: rtl/debug_capture_buffer.sv
// DEPTH-entry trace store: sequential writes up to exactly DEPTH entries,
// sequential pops, with flags marking the final write and the final pop.
module debug_capture_buffer
    import debug_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr,
    input  logic [OUT_W-1:0] wr_data,
    input  logic             rd,
    output logic [OUT_W-1:0] rd_data,
    output logic             full,
    output logic             last_wr,
    output logic             last_pop
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [OUT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] wr_cnt;
    logic             wr_ok;

    assign full     = (wr_cnt == CNT_W'(DEPTH));
    assign last_wr  = (wr_cnt == CNT_W'(DEPTH - 1));
    assign last_pop = (rd_ptr == PTR_W'(DEPTH - 1));
    assign wr_ok    = wr && !full && !clr;
    assign rd_data  = mem[rd_ptr];

    // Pointer and write-count bookkeeping; a clear restarts both sides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            wr_cnt <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            wr_cnt <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Sample storage; contents are only meaningful after being written.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end
endmodule

// File: rtl/debug_trace_module.sv
// Debug observation port for the SNN core: live channel view, rotating
// channel scan, or spike-triggered capture with pop-driven readout.
module debug_trace_module
    import debug_pkg::*;
#(
    parameter int NBITS    = 4,
    parameter int N_POT    = 10,
    parameter int N_SPK    = 8,
    parameter int OUT_W    = 8,
    parameter int DEPTH    = 16,
    parameter int SCAN_DIV = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    debug_trace_module_if.slave  bus
);
    localparam logic [3:0] SPK_CHAN = 4'(N_POT);
    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int PEXT_W = (NBITS > OUT_W) ? NBITS : OUT_W;
    localparam int SEXT_W = (N_SPK > OUT_W) ? N_SPK : OUT_W;

    logic [6:0]               cfg;
    logic                     unused_rsvd;
    logic [1:0]               state;
    logic [3:0]               scan_idx;
    logic [DIV_W-1:0]         scan_div;
    logic [3:0]               cfg_chan;
    logic [3:0]               src_chan;
    logic [1:0]               cfg_mode;
    logic [1:0]               new_mode;
    logic                     cfg_sext;
    logic                     trig;
    logic                     buf_clr;
    logic                     buf_wr;
    logic                     buf_rd;
    logic                     buf_full;
    logic                     buf_last_wr;
    logic                     buf_last_pop;
    logic [OUT_W-1:0]         sample;
    logic [OUT_W-1:0]         buf_rd_data;
    logic signed [NBITS-1:0]  pot [N_POT];
    logic signed [NBITS-1:0]  pot_sel;
    logic [OUT_W-1:0]         out_data_p0;
    logic                     out_vld_p0;
    logic [3:0]               out_chan_p0;

    // Potential: sign- or zero-extend when narrower, keep low bits when wider.
    function automatic logic [OUT_W-1:0] fmt_pot(input logic signed [NBITS-1:0] p,
                                                 input logic sext);
        logic signed [PEXT_W-1:0] e;
        if (sext) e = PEXT_W'(p);
        else      e = PEXT_W'($unsigned(p));
        return e[OUT_W-1:0];
    endfunction

    // Spike vector: always zero-extended, low bits kept when wider.
    function automatic logic [OUT_W-1:0] fmt_spk(input logic [N_SPK-1:0] s);
        logic [SEXT_W-1:0] e;
        e = SEXT_W'(s);
        return e[OUT_W-1:0];
    endfunction

    assign unused_rsvd = bus.debug_config_in[7];
    assign cfg_chan    = cfg[CHAN_MSB:CHAN_LSB];
    assign cfg_mode    = cfg[MODE_MSB:MODE_LSB];
    assign cfg_sext    = cfg[SEXT_BIT];
    assign new_mode    = bus.debug_config_in[MODE_MSB:MODE_LSB];
    assign trig        = |bus.output_spikes_layer1;

    // A config write takes priority over triggers and pops in the same cycle.
    assign buf_clr = bus.en;
    assign buf_wr  = !bus.en && !buf_full &&
                     (((state == ST_ARMED) && trig) || (state == ST_CAPTURE));
    assign buf_rd  = !bus.en && (state == ST_READOUT) && bus.rd_en;

    // Channel selection and formatting of the current sample.
    always_comb begin
        for (int k = 0; k < N_POT; k++) begin
            pot[k] = bus.membrane_potentials[k*NBITS +: NBITS];
        end
        src_chan = (cfg_mode == MODE_SCAN) ? scan_idx : cfg_chan;
        pot_sel  = '0;
        for (int k = 0; k < N_POT; k++) begin
            if (src_chan == 4'(k)) pot_sel = pot[k];
        end
        sample = (src_chan < SPK_CHAN) ? fmt_pot(pot_sel, cfg_sext)
                                       : fmt_spk(bus.output_spikes_layer1);
    end

    // Config register and capture state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg   <= '0;
            state <= ST_IDLE;
        end else if (bus.en) begin
            cfg   <= bus.debug_config_in[6:0];
            state <= (new_mode == MODE_CAPTURE) ? ST_ARMED : ST_IDLE;
        end else begin
            case (state)
                ST_ARMED:   if (trig) state <= ST_CAPTURE;
                ST_CAPTURE: if (buf_last_wr) state <= ST_READOUT;
                ST_READOUT: if (bus.rd_en && buf_last_pop) state <= ST_IDLE;
                default:    ;
            endcase
        end
    end

    // Scan rotation: hold each channel SCAN_DIV cycles, wrap after the spike channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx <= '0;
            scan_div <= '0;
        end else if (bus.en) begin
            scan_idx <= '0;
            scan_div <= '0;
        end else if (cfg_mode == MODE_SCAN) begin
            if (scan_div == DIV_W'(SCAN_DIV - 1)) begin
                scan_div <= '0;
                scan_idx <= (scan_idx == SPK_CHAN) ? 4'd0 : scan_idx + 4'd1;
            end else begin
                scan_div <= scan_div + 1'b1;
            end
        end
    end

    // Output register: buffer entry in readout, hold while capturing, else live sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_p0 <= '0;
            out_vld_p0  <= 1'b0;
            out_chan_p0 <= '0;
        end else if (state == ST_READOUT) begin
            out_data_p0 <= buf_rd_data;
            out_vld_p0  <= 1'b1;
            out_chan_p0 <= cfg_chan;
        end else if (cfg_mode == MODE_CAPTURE) begin
            out_vld_p0  <= 1'b0;
        end else begin
            out_data_p0 <= sample;
            out_vld_p0  <= 1'b1;
            out_chan_p0 <= src_chan;
        end
    end

    assign bus.debug_select = out_data_p0;
    assign bus.debug_valid  = out_vld_p0;
    assign bus.debug_chan   = out_chan_p0;
    assign bus.debug_state  = state;

    debug_capture_buffer #(
        .DEPTH (DEPTH),
        .OUT_W (OUT_W)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (buf_clr),
        .wr       (buf_wr),
        .wr_data  (sample),
        .rd       (buf_rd),
        .rd_data  (buf_rd_data),
        .full     (buf_full),
        .last_wr  (buf_last_wr),
        .last_pop (buf_last_pop)
    );
endmodule

// File: tb/tb_debug_trace_module.sv
// Directed bench for debug_trace_module: live, scan, capture/readout,
// abort by config write, simultaneous events and asynchronous reset.
module tb_debug_trace_module;
    localparam int NBITS = 4, N_POT = 10, N_SPK = 8, OUT_W = 8, DEPTH = 16, SCAN_DIV = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    debug_trace_module_if #(.NBITS(NBITS), .N_POT(N_POT), .N_SPK(N_SPK), .OUT_W(OUT_W)) bus ();

    debug_trace_module #(
        .NBITS(NBITS), .N_POT(N_POT), .N_SPK(N_SPK),
        .OUT_W(OUT_W), .DEPTH(DEPTH), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pot(input int k, input logic [3:0] v);
        bus.membrane_potentials[k*4 +: 4] = v;
    endtask

    task automatic write_cfg(input logic [7:0] c);
        bus.debug_config_in = c;
        bus.en = 1'b1;
        tick();
        bus.en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.debug_config_in = 8'h00;
        bus.rd_en = 1'b0;
        bus.output_spikes_layer1 = '0;
        bus.membrane_potentials = '0;
        set_pot(0, 4'h5);
        #23;
        total_cnt++; if (bus.debug_select !== 8'h00) $display("FAIL reset_select: got %h exp 00", bus.debug_select); else pass_cnt++;
        total_cnt++; if (bus.debug_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", bus.debug_valid); else pass_cnt++;
        total_cnt++; if ({bus.debug_chan, bus.debug_state} !== 6'h00) $display("FAIL reset_chan_state: got %h/%h exp 0/0", bus.debug_chan, bus.debug_state); else pass_cnt++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        total_cnt++; if (bus.debug_select !== 8'h05) $display("FAIL first_live_select: got %h exp 05", bus.debug_select); else pass_cnt++;
        total_cnt++; if (bus.debug_valid !== 1'b1) $display("FAIL first_live_valid: got %b exp 1", bus.debug_valid); else pass_cnt++;
        total_cnt++; if ({bus.debug_chan, bus.debug_state} !== 6'h00) $display("FAIL first_live_chan_state: got %h/%h exp 0/0", bus.debug_chan, bus.debug_state); else pass_cnt++;
    endtask

    task automatic test_live_sext();
        set_pot(3, 4'b1010);
        write_cfg(8'h43);
        tick();
        total_cnt++; if (bus.debug_select !== 8'hFA) $display("FAIL live_sext: got %h exp FA", bus.debug_select); else pass_cnt++;
        total_cnt++; if (bus.debug_chan !== 4'd3) $display("FAIL live_sext_chan: got %0d exp 3", bus.debug_chan); else pass_cnt++;
        write_cfg(8'h03);
        tick();
        total_cnt++; if (bus.debug_select !== 8'h0A) $display("FAIL live_zext: got %h exp 0A", bus.debug_select); else pass_cnt++;
    endtask

    task automatic test_spike_chan();
        bus.output_spikes_layer1 = 8'hA5;
        write_cfg(8'h0C);
        tick();
        total_cnt++; if (bus.debug_select !== 8'hA5) $display("FAIL spike_chan_data: got %h exp A5", bus.debug_select); else pass_cnt++;
        total_cnt++; if (bus.debug_chan !== 4'd12) $display("FAIL spike_chan_idx: got %0d exp 12", bus.debug_chan); else pass_cnt++;
    endtask

    task automatic test_scan();
        logic [3:0] exp_c;
        logic [7:0] exp_d;
        for (int k = 0; k < N_POT; k++) set_pot(k, 4'(k));
        bus.output_spikes_layer1 = 8'h80;
        write_cfg(8'h10);
        for (int s = 0; s < 48; s++) begin
            tick();
            exp_c = 4'((s / 4) % 11);
            exp_d = (exp_c < 4'd10) ? {4'h0, exp_c} : 8'h80;
            total_cnt++;
            if ({bus.debug_valid, bus.debug_chan, bus.debug_select} !== {1'b1, exp_c, exp_d})
                $display("FAIL scan_step%0d: got v%b c%0d d%h exp v1 c%0d d%h", s, bus.debug_valid, bus.debug_chan, bus.debug_select, exp_c, exp_d);
            else pass_cnt++;
        end
    endtask

    task automatic test_capture();
        logic [7:0] exp_d;
        bus.output_spikes_layer1 = 8'h00;
        set_pot(1, 4'd0);
        write_cfg(8'h21);
        tick();
        total_cnt++; if ({bus.debug_state, bus.debug_valid} !== {2'd1, 1'b0}) $display("FAIL cap_armed: got st%0d v%b exp st1 v0", bus.debug_state, bus.debug_valid); else pass_cnt++;
        set_pot(1, 4'd1); tick();
        set_pot(1, 4'd2); tick();
        set_pot(1, 4'd3);
        bus.output_spikes_layer1 = 8'h01;
        tick();
        bus.output_spikes_layer1 = 8'h00;
        total_cnt++; if (bus.debug_state !== 2'd2) $display("FAIL cap_triggered: got %0d exp 2", bus.debug_state); else pass_cnt++;
        for (int i = 1; i < 16; i++) begin
            set_pot(1, 4'(3 + i));
            tick();
            total_cnt++;
            if (bus.debug_state !== ((i < 15) ? 2'd2 : 2'd3))
                $display("FAIL cap_state_w%0d: got %0d exp %0d", i, bus.debug_state, (i < 15) ? 2 : 3);
            else pass_cnt++;
        end
        tick();
        for (int j = 0; j < 16; j++) begin
            exp_d = {4'h0, 4'(3 + j)};
            total_cnt++;
            if ({bus.debug_valid, bus.debug_chan, bus.debug_select} !== {1'b1, 4'd1, exp_d})
                $display("FAIL readout_e%0d: got v%b c%0d d%h exp v1 c1 d%h", j, bus.debug_valid, bus.debug_chan, bus.debug_select, exp_d);
            else pass_cnt++;
            bus.rd_en = 1'b1; tick();
            bus.rd_en = 1'b0; tick();
        end
        total_cnt++; if ({bus.debug_state, bus.debug_valid} !== {2'd0, 1'b0}) $display("FAIL readout_done: got st%0d v%b exp st0 v0", bus.debug_state, bus.debug_valid); else pass_cnt++;
        total_cnt++; if (bus.debug_select !== 8'h02) $display("FAIL readout_hold: got %h exp 02", bus.debug_select); else pass_cnt++;
        bus.rd_en = 1'b1; tick();
        bus.rd_en = 1'b0;
        bus.output_spikes_layer1 = 8'h01; tick();
        bus.output_spikes_layer1 = 8'h00;
        total_cnt++; if ({bus.debug_state, bus.debug_valid} !== {2'd0, 1'b0}) $display("FAIL no_rearm: got st%0d v%b exp st0 v0", bus.debug_state, bus.debug_valid); else pass_cnt++;
    endtask

    task automatic test_abort();
        write_cfg(8'h21);
        tick();
        set_pot(1, 4'd7);
        bus.output_spikes_layer1 = 8'h01; tick();
        bus.output_spikes_layer1 = 8'h00;
        for (int i = 0; i < 4; i++) tick();
        total_cnt++; if (bus.debug_state !== 2'd2) $display("FAIL abort_pre_state: got %0d exp 2", bus.debug_state); else pass_cnt++;
        total_cnt++; if (dut.u_buf.wr_cnt !== 5'd5) $display("FAIL abort_pre_count: got %0d exp 5", dut.u_buf.wr_cnt); else pass_cnt++;
        set_pot(2, 4'd9);
        write_cfg(8'h02);
        total_cnt++; if (bus.debug_state !== 2'd0) $display("FAIL abort_state: got %0d exp 0", bus.debug_state); else pass_cnt++;
        total_cnt++; if ({dut.u_buf.wr_cnt, dut.u_buf.rd_ptr} !== 9'h000) $display("FAIL abort_ptrs: got %0d/%0d exp 0/0", dut.u_buf.wr_cnt, dut.u_buf.rd_ptr); else pass_cnt++;
        tick();
        total_cnt++; if ({bus.debug_valid, bus.debug_chan, bus.debug_select} !== {1'b1, 4'd2, 8'h09}) $display("FAIL abort_live: got v%b c%0d d%h exp v1 c2 d09", bus.debug_valid, bus.debug_chan, bus.debug_select); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        bus.output_spikes_layer1 = 8'h01;
        write_cfg(8'h21);
        total_cnt++; if (bus.debug_state !== 2'd1) $display("FAIL en_beats_trigger: got %0d exp 1", bus.debug_state); else pass_cnt++;
        tick();
        bus.output_spikes_layer1 = 8'h00;
        total_cnt++; if (bus.debug_state !== 2'd2) $display("FAIL retrigger: got %0d exp 2", bus.debug_state); else pass_cnt++;
        for (int i = 0; i < 15; i++) tick();
        total_cnt++; if (bus.debug_state !== 2'd3) $display("FAIL reach_readout: got %0d exp 3", bus.debug_state); else pass_cnt++;
        tick();
        bus.rd_en = 1'b1; tick();
        bus.rd_en = 1'b0; tick();
        total_cnt++; if ({bus.debug_valid, bus.debug_select} !== {1'b1, 8'h07}) $display("FAIL pre_reset_entry: got v%b d%h exp v1 d07", bus.debug_valid, bus.debug_select); else pass_cnt++;
        #3 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus.debug_select, bus.debug_valid, bus.debug_chan, bus.debug_state} !== 15'h0)
            $display("FAIL async_reset: got d%h v%b c%0d st%0d exp all 0", bus.debug_select, bus.debug_valid, bus.debug_chan, bus.debug_state);
        else pass_cnt++;
        #10 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_live_sext();
        test_spike_chan();
        test_scan();
        test_capture();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/debug_trace_module.md
Name: debug_trace_module

Overview:
Parametrised debug observation block for the SNN core. It drives one OUT_W-bit debug port from any membrane-potential channel or from the layer-1 spike vector, and supports three modes:
- LIVE: static selection.
- SCAN: auto-scan, rotating through all channels.
- CAPTURE: spike-triggered capture into a DEPTH-entry trace buffer, then read out with a pop handshake.

It sits between the network core and the chip output pins and is configured through the existing 8-bit debug config path.

Parameters:
NBITS, 4, width of one membrane potential
N_POT, 10, number of membrane-potential channels (1..15)
N_SPK, 8, width of the layer-1 spike vector
OUT_W, 8, debug output width
DEPTH, 16, capture buffer entries (power of 2, >=2)
SCAN_DIV, 4, cycles each channel is held in SCAN mode (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  config write enable
debug_config_in  in  8  config word: [3:0] chan, [5:4] mode, [6] sext, [7] reserved (ignored)
membrane_potentials  in  N_POT*NBITS  flattened; channel k = bits [(k+1)*NBITS-1 : k*NBITS]
output_spikes_layer1  in  N_SPK  spike vector; channel index N_POT; also the capture trigger
rd_en  in  1  pop one capture entry (READOUT state only)
debug_select  out  OUT_W  registered debug data
debug_valid  out  1  debug_select holds meaningful data
debug_chan  out  4  channel index of the sample on debug_select
debug_state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 READOUT

Behaviour:
- Reset (async, rst_n=0):
  - config register = 0, which gives LIVE, chan 0, zero-extend.
  - debug_select=0, debug_valid=0, debug_chan=0, state IDLE.
  - Scan counter, buffer pointers and sample counter = 0.
- Config register:
  - Loaded at the clk edge where en=1; the new config takes effect from the next cycle.
  - A write always aborts any capture or readout: pointers cleared, state re-evaluated from the new mode.
- Channel map:
  - Channels 0..N_POT-1 are potentials.
  - Channel N_POT and any higher index select output_spikes_layer1.
- Width rule:
  - Source narrower than OUT_W: sign-extend if sext=1, else zero-extend. Spikes are always zero-extended.
  - Source wider than OUT_W: keep the low OUT_W bits.
- Mode 0, LIVE (mode 3 behaves identically):
  - Each cycle, debug_select <= formatted(chan) and debug_chan <= chan, so latency is 1 cycle.
  - debug_valid=1 from the first edge after reset release. State stays IDLE.
- Mode 1, SCAN:
  - A scan index starts at 0 on config write and advances every SCAN_DIV cycles.
  - It wraps from N_POT back to 0, so N_POT+1 channels are visited in total.
  - debug_select and debug_chan are registered from the current scan index, with 1-cycle latency.
  - debug_valid=1. The chan field is ignored.
- Mode 2, CAPTURE: state machine.
  - On config write: IDLE -> ARMED. debug_valid=0 while ARMED.
  - ARMED -> CAPTURE on the first cycle where |output_spikes_layer1 = 1. The sample of chan in that same cycle is entry 0.
  - CAPTURE writes one formatted sample per cycle. Spikes are ignored in this state.
  - After DEPTH writes: CAPTURE -> READOUT.
  - READOUT:
    - debug_select shows the entry at rd_ptr (registered), debug_valid=1, debug_chan=chan.
    - rd_en advances rd_ptr. Data for the next entry is visible the cycle after the pop.
  - The pop of entry DEPTH-1 goes to IDLE: debug_valid=0, debug_select holds its last value.
  - rd_en outside READOUT is ignored.
  - Re-arming requires a new config write.
- Simultaneous events:
  - en together with a trigger: the config write wins and the trigger is ignored.
  - en together with rd_en: the config write wins.
- No overflow is possible: writes stop at exactly DEPTH entries.

Decomposition:
- Package debug_pkg holds:
  - mode encodings: MODE_LIVE, MODE_SCAN, MODE_CAPTURE
  - state encodings
  - config field positions (CHAN_LSB/MSB, MODE_LSB/MSB, SEXT_BIT)
- Sub-module debug_capture_buffer holds:
  - DEPTH x OUT_W storage with wr_ptr and rd_ptr of $clog2(DEPTH) bits
  - a write-count full flag and a last-pop flag
- The top level contains the config register, format/mux logic, scan counter and state machine.

Test Plan:
1. Reset release; pot[0]=4'h5 -> debug_select=8'h05, debug_valid=1 one cycle after the first edge; debug_state=0.
2. Write config 8'h43 (LIVE, chan 3, sext) with pot[3]=4'b1010 -> 8'hFA next cycle. Write 8'h03 -> 8'h0A.
3. Write 8'h0C (chan 12) with spikes=8'hA5 -> debug_select=8'hA5, debug_chan=12.
4. Write 8'h10 (SCAN), pot[k]=k, spikes=8'h80 -> debug_chan walks 0,1,...,10,0, each value held 4 cycles. Sample values equal k; channel 10 gives 8'h80.
5. Write 8'h21 (CAPTURE, chan 1); pot[1] ramps +1 per cycle from 0; spike=1 at cycle when pot[1]=3 -> ARMED, then CAPTURE for 16 cycles, then READOUT. 16 rd_en pops return 3..15,0,1,2 (4-bit wrap), then IDLE with debug_valid=0.
6. Mid-CAPTURE after 5 writes, write 8'h02 -> next cycle LIVE chan 2, pointers cleared. Mid-READOUT, drive rst_n low asynchronously -> all outputs 0 immediately.
